// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit.
// States, legacy 3-bit opcodes, trap causes and the strobe bundle.
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_MFI = 3'b001;
  localparam logic [2:0] OP_MW  = 3'b010;
  localparam logic [2:0] OP_MR  = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_JCE = 3'b101;
  localparam logic [2:0] OP_MB  = 3'b110;
  localparam logic [2:0] OP_JCN = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic j;
    logic jc;
    logic ina;
    logic rm;
    logic wm;
    logic sin;
    logic sout;
    logic wr;
    logic neq;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '0;

endpackage

// File: rtl/cu_strobe_decode.sv
// Legacy datapath strobe encoding: opcode[2:0] + state -> strobes.
// Pure combinational, shared with the single-cycle core.
module cu_strobe_decode
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opcode,
  output strobe_t    strobe
);

  // strobes only fire in EXEC, MEM and WB
  always_comb begin
    strobe = STROBE_NONE;
    unique case (state)
      EXEC: begin
        unique case (opcode)
          OP_R:   strobe.sout = 1'b1;
          OP_MFI: begin
            strobe.ina = 1'b1;
            strobe.sin = 1'b1;
          end
          OP_MW:  ;
          OP_MR:  ;
          OP_J:   strobe.j = 1'b1;
          OP_JCE: strobe.jc = 1'b1;
          OP_MB:  strobe.wr = 1'b1;
          OP_JCN: begin
            strobe.jc  = 1'b1;
            strobe.neq = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        strobe.wm = (opcode == OP_MW);
        strobe.rm = (opcode == OP_MR);
      end
      WB:      strobe.wr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// handshake, wait-state timeout and illegal-opcode trap.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                eq_flag,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                j,
  output logic                jc,
  output logic                ina,
  output logic                rm,
  output logic                wm,
  output logic                sin,
  output logic                sout,
  output logic                wr,
  output logic                neq,
  output logic                busy,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t              state;
  state_t              state_nx;
  logic [2:0]          op_q;
  logic [TO_W-1:0]     to_cnt;
  logic [1:0]          cause_q;
  logic [1:0]          cause_nx;
  logic [OPCODE_W-1:0] op_hi;
  logic                illegal;
  logic                waiting;
  logic                expired;
  state_t              boundary;
  strobe_t             strobe;

  // any opcode bit above [2:0] makes it illegal
  assign op_hi   = ir_opcode >> 3;
  assign illegal = |op_hi;

  assign waiting = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign expired = (MEM_TIMEOUT != 0) && waiting
                && (to_cnt == TO_W'(MEM_TIMEOUT));

  // halting is only allowed at an instruction boundary
  assign boundary = run ? FETCH : IDLE;

  cu_strobe_decode u_strobe (
    .state  (state),
    .opcode (op_q),
    .strobe (strobe)
  );

  // state, opcode latch, timeout counter and trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      to_cnt  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (state == DECODE) begin
        op_q <= ir_opcode[2:0];
      end
      if (state_nx != state) begin
        to_cnt <= '0;
      end else if (waiting && (to_cnt != '1)) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // next state and Moore outputs
  always_comb begin
    state_nx   = state;
    cause_nx   = cause_q;
    mem_req    = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    busy       = 1'b0;
    trap       = 1'b0;
    trap_cause = cause_q;
    j          = strobe.j;
    jc         = strobe.jc;
    ina        = strobe.ina;
    rm         = strobe.rm;
    wm         = strobe.wm;
    sin        = strobe.sin;
    sout       = strobe.sout;
    wr         = strobe.wr;
    neq        = strobe.neq;
    unique case (state)
      IDLE: begin
        if (run) state_nx = FETCH;
      end
      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
        if (mem_ready) begin
          state_nx = DECODE;
        end else if (expired) begin
          state_nx = TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (illegal) begin
          state_nx = TRAP;
          cause_nx = CAUSE_ILLEGAL;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        pc_load = (op_q == OP_J)
               || ((op_q == OP_JCE) && eq_flag)
               || ((op_q == OP_JCN) && !eq_flag);
        if ((op_q == OP_MW) || (op_q == OP_MR)) begin
          state_nx = MEM;
        end else begin
          state_nx = boundary;
        end
      end
      MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          state_nx = (op_q == OP_MR) ? WB : boundary;
        end else if (expired) begin
          state_nx = TRAP;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        busy     = 1'b1;
        state_nx = boundary;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (OPCODE_W=4, timeout 3).
// Expected output vectors are queued per cycle and checked at negedge.
module tb_multicycle_control_unit;

  localparam logic [16:0] REQ  = 17'd1 << 16;
  localparam logic [16:0] IRL  = 17'd1 << 15;
  localparam logic [16:0] PCI  = 17'd1 << 14;
  localparam logic [16:0] PCL  = 17'd1 << 13;
  localparam logic [16:0] SJ   = 17'd1 << 12;
  localparam logic [16:0] SJC  = 17'd1 << 11;
  localparam logic [16:0] SINA = 17'd1 << 10;
  localparam logic [16:0] SRM  = 17'd1 << 9;
  localparam logic [16:0] SWM  = 17'd1 << 8;
  localparam logic [16:0] SSIN = 17'd1 << 7;
  localparam logic [16:0] SOUT = 17'd1 << 6;
  localparam logic [16:0] SWR  = 17'd1 << 5;
  localparam logic [16:0] SNEQ = 17'd1 << 4;
  localparam logic [16:0] BUSY = 17'd1 << 3;
  localparam logic [16:0] TRP  = 17'd1 << 2;
  localparam logic [16:0] CTO  = 17'd2;
  localparam logic [16:0] CIL  = 17'd1;
  localparam logic [16:0] FOK  = REQ | IRL | PCI | BUSY;

  localparam logic [3:0] O_R   = 4'd0;
  localparam logic [3:0] O_MFI = 4'd1;
  localparam logic [3:0] O_MW  = 4'd2;
  localparam logic [3:0] O_MR  = 4'd3;
  localparam logic [3:0] O_J   = 4'd4;
  localparam logic [3:0] O_JCE = 4'd5;
  localparam logic [3:0] O_MB  = 4'd6;
  localparam logic [3:0] O_JCN = 4'd7;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] ir_opcode;
  logic       eq_flag;
  logic       mem_ready;
  logic       mem_req, ir_load, pc_inc, pc_load;
  logic       j, jc, ina, rm, wm, sin, sout, wr, neq;
  logic       busy, trap;
  logic [1:0] trap_cause;
  logic [16:0] obs;

  typedef struct {
    logic [16:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  multicycle_control_unit #(
    .OPCODE_W    (4),
    .MEM_TIMEOUT (3),
    .TO_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .ir_opcode  (ir_opcode),
    .eq_flag    (eq_flag),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .j          (j),
    .jc         (jc),
    .ina        (ina),
    .rm         (rm),
    .wm         (wm),
    .sin        (sin),
    .sout       (sout),
    .wr         (wr),
    .neq        (neq),
    .busy       (busy),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  assign obs = {mem_req, ir_load, pc_inc, pc_load,
                j, jc, ina, rm, wm, sin, sout, wr, neq,
                busy, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check();
    item_t it;
    it = sb.pop_front();
    n_tests++;
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
    end
  endtask

  task automatic now(input logic [16:0] e, input string tag);
    item_t it;
    it.exp = e;
    it.tag = tag;
    sb.push_back(it);
    check();
  endtask

  task automatic cyc(input logic [16:0] e, input string tag);
    item_t it;
    it.exp = e;
    it.tag = tag;
    sb.push_back(it);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] opc, input logic [16:0] e,
                     input string tag);
    ir_opcode = opc;
    cyc(FOK, {tag, "_fetch"});
    cyc(BUSY, {tag, "_decode"});
    cyc(e | BUSY, {tag, "_exec"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    eq_flag   = 1'b0;
    ir_opcode = O_R;
    repeat (2) @(posedge clk);
    #1;
    cyc('0, "reset");

    rst_n     = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;
    cyc('0, "idle_run");
    alu(O_R, SOUT, "r");
    alu(O_J, SJ | PCL, "j");

    ir_opcode = O_MR;
    cyc(FOK, "mr_fetch");
    cyc(BUSY, "mr_decode");
    cyc(BUSY, "mr_exec");
    cyc(REQ | SRM | BUSY, "mr_mem");
    cyc(SWR | BUSY, "mr_wb");

    eq_flag = 1'b1;
    alu(O_JCE, SJC | PCL, "jce_eq1");
    alu(O_JCN, SJC | SNEQ, "jcn_eq1");
    eq_flag = 1'b0;
    alu(O_JCE, SJC, "jce_eq0");
    alu(O_JCN, SJC | SNEQ | PCL, "jcn_eq0");
    alu(O_MFI, SINA | SSIN, "mfi");
    alu(O_MB, SWR, "mb");

    ir_opcode = O_MW;
    cyc(FOK, "mw_fetch");
    cyc(BUSY, "mw_decode");
    cyc(BUSY, "mw_exec");
    cyc(REQ | SWM | BUSY, "mw_mem");

    ir_opcode = O_R;
    mem_ready = 1'b0;
    cyc(REQ | BUSY, "fwait0");
    cyc(REQ | BUSY, "fwait1");
    mem_ready = 1'b1;
    cyc(FOK, "fwait_done");
    cyc(BUSY, "halt_decode");
    run = 1'b0;
    cyc(SOUT | BUSY, "halt_exec");
    cyc('0, "halted0");
    cyc('0, "halted1");

    run       = 1'b1;
    ir_opcode = O_MW;
    cyc('0, "idle_resume");
    cyc(FOK, "lim_fetch");
    cyc(BUSY, "lim_decode");
    cyc(BUSY, "lim_exec");
    mem_ready = 1'b0;
    cyc(REQ | SWM | BUSY, "lim_wait0");
    cyc(REQ | SWM | BUSY, "lim_wait1");
    cyc(REQ | SWM | BUSY, "lim_wait2");
    mem_ready = 1'b1;
    cyc(REQ | SWM | BUSY, "lim_ready");
    cyc(FOK, "lim_no_trap");
    cyc(BUSY, "ar_decode");
    cyc(BUSY, "ar_exec");
    mem_ready = 1'b0;
    cyc(REQ | SWM | BUSY, "ar_mem0");
    cyc(REQ | SWM | BUSY, "ar_mem1");
    #2;
    rst_n = 1'b0;
    #1;
    now('0, "async_reset");
    @(posedge clk);
    #1;
    cyc('0, "in_reset");

    rst_n     = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;
    cyc('0, "rel_idle");
    cyc(FOK, "rel_fetch");
    cyc(BUSY, "to_decode");
    cyc(BUSY, "to_exec");
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(REQ | SWM | BUSY, $sformatf("to_wait%0d", i));
    end
    cyc(TRP | CTO, "to_trap");
    for (int i = 0; i < 4; i++) begin
      run       = i[0];
      mem_ready = i[1];
      cyc(TRP | CTO, $sformatf("to_hold%0d", i));
    end

    rst_n = 1'b0;
    cyc('0, "rst_after_to");
    rst_n     = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b1;
    ir_opcode = 4'b1010;
    cyc('0, "ill_idle");
    cyc(FOK, "ill_fetch");
    cyc(BUSY, "ill_decode");
    cyc(TRP | CIL, "ill_trap");
    for (int i = 0; i < 4; i++) begin
      run = ~i[0];
      cyc(TRP | CIL, $sformatf("ill_hold%0d", i));
    end
    rst_n = 1'b0;
    cyc('0, "rst_after_ill");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
